// File: rtl/scoreboard_match_ctrl.sv
// scoreboard_match_ctrl
//   Match controller for the two-player scoreboard: arbitrates point pulses,
//   owns both scores with a one-level undo, detects the winner and sequences
//   the shared two-digit display (BCD digits plus blank strobe).
//
// Ports
//   clk_1khz_i      system clock, rising edge
//   rst_i           asynchronous active-high reset
//   point_p1_i      one-cycle pulse, player 1 claims a point
//   point_p2_i      one-cycle pulse, player 2 claims a point
//   undo_i          one-cycle pulse, revoke last accepted point
//   score_p1_o      player 1 score (binary)
//   score_p2_o      player 2 score (binary)
//   disp_player_o   displayed player (0 = P1, 1 = P2)
//   disp_tens_o     BCD tens of displayed score (one cycle behind selection)
//   disp_ones_o     BCD ones of displayed score (one cycle behind selection)
//   blank_o         display blank strobe
//   game_over_o     high while in GAME_OVER
//   winner_o        winning player, valid while game_over_o = 1
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_PLAY      | accepting point and undo pulses
// ST_LOCKOUT   | ignoring all pulses for LOCKOUT_CYC cycles after a point
// ST_GAME_OVER | winner shown blinking; undo resumes, a point starts anew
module scoreboard_match_ctrl #(
  parameter int WIN_SCORE   = 21,
  parameter int SHOW_CYC    = 2000,
  parameter int LOCKOUT_CYC = 200,
  parameter int BLINK_CYC   = 250
) (
  input  logic       clk_1khz_i,
  input  logic       rst_i,
  input  logic       point_p1_i,
  input  logic       point_p2_i,
  input  logic       undo_i,
  output logic [6:0] score_p1_o,
  output logic [6:0] score_p2_o,
  output logic       disp_player_o,
  output logic [3:0] disp_tens_o,
  output logic [3:0] disp_ones_o,
  output logic       blank_o,
  output logic       game_over_o,
  output logic       winner_o
);

  localparam int SHOW_W  = (SHOW_CYC    > 1) ? $clog2(SHOW_CYC)    : 1;
  localparam int LOCK_W  = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam int BLINK_W = (BLINK_CYC   > 1) ? $clog2(BLINK_CYC)   : 1;

  localparam logic [6:0]         WIN_Q      = 7'(WIN_SCORE);
  localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(SHOW_CYC - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LOAD  = LOCK_W'(LOCKOUT_CYC - 1);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYC - 1);

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_LOCKOUT   = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  state_t             state_q;
  logic [6:0]         score_p1_q, score_p2_q;
  logic               disp_player_q, blank_q, game_over_q, winner_q;
  logic [3:0]         disp_tens_q, disp_ones_q;
  logic               rr_p2_q;       // round-robin priority: 1 = P2 wins a tie
  logic               hist_valid_q;
  logic               last_p2_q;     // last accepted scorer
  logic [SHOW_W-1:0]  show_cnt_q;
  logic [LOCK_W-1:0]  lock_cnt_q;
  logic [BLINK_W-1:0] blink_cnt_q;

  logic       any_point_d, grant_p2_d;
  logic [6:0] inc_score_d, sel_score_d;
  logic [3:0] tens_d, ones_d;

  always_comb begin
    any_point_d = point_p1_i | point_p2_i;
    // P2 is granted when it presses alone, or on a tie while holding priority
    grant_p2_d  = point_p2_i & (~point_p1_i | rr_p2_q);
    inc_score_d = (grant_p2_d ? score_p2_q : score_p1_q) + 7'd1;
    sel_score_d = disp_player_q ? score_p2_q : score_p1_q;
    tens_d      = 4'(sel_score_d / 7'd10);
    ones_d      = 4'(sel_score_d % 7'd10);
  end

  always_ff @(posedge clk_1khz_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_PLAY;
      score_p1_q    <= '0;
      score_p2_q    <= '0;
      disp_player_q <= 1'b0;
      disp_tens_q   <= '0;
      disp_ones_q   <= '0;
      blank_q       <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      rr_p2_q       <= 1'b0;
      hist_valid_q  <= 1'b0;
      last_p2_q     <= 1'b0;
      show_cnt_q    <= '0;
      lock_cnt_q    <= '0;
      blink_cnt_q   <= '0;
    end else begin
      disp_tens_q <= tens_d;
      disp_ones_q <= ones_d;

      // Alternation runs in PLAY/LOCKOUT; event branches below override it.
      if (state_q != ST_GAME_OVER) begin
        if (show_cnt_q == SHOW_LAST) begin
          show_cnt_q    <= '0;
          disp_player_q <= ~disp_player_q;
        end else begin
          show_cnt_q <= show_cnt_q + 1'b1;
        end
      end

      case (state_q)
        ST_PLAY: begin
          if (undo_i) begin
            // undo wins over any coincident point pulse
            if (hist_valid_q) begin
              if (last_p2_q) score_p2_q <= score_p2_q - 7'd1;
              else           score_p1_q <= score_p1_q - 7'd1;
              hist_valid_q  <= 1'b0;
              disp_player_q <= last_p2_q;
              show_cnt_q    <= '0;
            end
          end else if (any_point_d) begin
            if (grant_p2_d) score_p2_q <= inc_score_d;
            else            score_p1_q <= inc_score_d;
            if (point_p1_i && point_p2_i) rr_p2_q <= ~grant_p2_d;
            last_p2_q     <= grant_p2_d;
            hist_valid_q  <= 1'b1;
            disp_player_q <= grant_p2_d;
            show_cnt_q    <= '0;
            if (inc_score_d == WIN_Q) begin
              state_q     <= ST_GAME_OVER;
              winner_q    <= grant_p2_d;
              game_over_q <= 1'b1;
              blank_q     <= 1'b0;
              blink_cnt_q <= BLINK_LOAD;
            end else begin
              state_q    <= ST_LOCKOUT;
              lock_cnt_q <= LOCK_LOAD;
            end
          end
        end

        ST_LOCKOUT: begin
          if (lock_cnt_q == '0) state_q    <= ST_PLAY;
          else                  lock_cnt_q <= lock_cnt_q - 1'b1;
        end

        ST_GAME_OVER: begin
          if (blink_cnt_q == '0) begin
            blank_q     <= ~blank_q;
            blink_cnt_q <= BLINK_LOAD;
          end else begin
            blink_cnt_q <= blink_cnt_q - 1'b1;
          end
          if (undo_i) begin
            if (hist_valid_q) begin
              if (winner_q) score_p2_q <= score_p2_q - 7'd1;
              else          score_p1_q <= score_p1_q - 7'd1;
              hist_valid_q  <= 1'b0;
              blank_q       <= 1'b0;
              game_over_q   <= 1'b0;
              disp_player_q <= winner_q;
              show_cnt_q    <= '0;
              state_q       <= ST_PLAY;
            end
          end else if (any_point_d) begin
            // new game: the pulse only clears, it does not score
            score_p1_q    <= '0;
            score_p2_q    <= '0;
            hist_valid_q  <= 1'b0;
            blank_q       <= 1'b0;
            game_over_q   <= 1'b0;
            disp_player_q <= 1'b0;
            show_cnt_q    <= '0;
            state_q       <= ST_PLAY;
          end
        end

        default: state_q <= ST_PLAY;
      endcase
    end
  end

  assign score_p1_o    = score_p1_q;
  assign score_p2_o    = score_p2_q;
  assign disp_player_o = disp_player_q;
  assign disp_tens_o   = disp_tens_q;
  assign disp_ones_o   = disp_ones_q;
  assign blank_o       = blank_q;
  assign game_over_o   = game_over_q;
  assign winner_o      = winner_q;

endmodule
